// File: rtl/maxpool_pkg.sv
// Shared types and helpers for the 2x2/stride-2 max-pool stream controller.
package maxpool_pkg;

  localparam int BITWIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Signed max at the default pixel width; ties return b (values are equal).
  function automatic logic signed [BITWIDTH_DEF-1:0] smax(
    input logic signed [BITWIDTH_DEF-1:0] a,
    input logic signed [BITWIDTH_DEF-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_stream_ctrl_if.sv
// Control, input-stream and output-stream signals of the max-pool controller.
interface maxpool_stream_ctrl_if
  import maxpool_pkg::*;
#(
  parameter int BITWIDTH = BITWIDTH_DEF
);
  logic                start;
  logic                busy;
  logic                done;
  logic [BITWIDTH-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  logic [BITWIDTH-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;

  // Upstream/downstream side (drives pixels, consumes pooled results).
  modport master (
    output start, in_data, in_valid, out_ready,
    input  busy, done, in_ready, out_data, out_valid, out_last
  );

  // Controller side.
  modport slave (
    input  start, in_data, in_valid, out_ready,
    output busy, done, in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/max2_signed.sv
// Combinational two-input signed maximum at full width, no widening.
module max2_signed #(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] y
);
  // Both operands are declared signed, so the compare is two's complement.
  assign y = (a > b) ? a : b;
endmodule

// File: rtl/maxpool_stream_ctrl.sv
// 2x2/stride-2 max-pool stream controller: raster in, pooled raster out,
// one half-width line buffer shared by every row pair and channel.
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// RUN   | accepting input beats, emitting pooled pixels
// DRAIN | all input taken, waiting for the final output handshake
// DONE  | one-cycle done pulse, then back to IDLE
module maxpool_stream_ctrl
  import maxpool_pkg::*;
#(
  parameter int BITWIDTH = BITWIDTH_DEF,
  parameter int CHANNELS = 2,
  parameter int IN_DIM   = 10
) (
  input logic            clk,
  input logic            rst,
  maxpool_stream_ctrl_if.slave bus
);
  localparam int OUT_DIM = IN_DIM / 2;
  localparam int CW  = $clog2(IN_DIM);
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int LW  = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam logic [CW-1:0]  DIM_MAX = CW'(IN_DIM - 1);
  localparam logic [CHW-1:0] CH_MAX  = CHW'(CHANNELS - 1);

  if ((IN_DIM % 2) != 0 || IN_DIM < 2) begin : g_bad_dim
    $error("maxpool_stream_ctrl: IN_DIM must be even and at least 2");
  end

  state_t state, state_next;

  logic [CW-1:0]  col, row;
  logic [CHW-1:0] ch;
  logic [LW-1:0]  lb_idx;

  logic signed [BITWIDTH-1:0] pair;
  logic signed [BITWIDTH-1:0] linebuf [OUT_DIM];
  logic signed [BITWIDTH-1:0] in_px, lb_rd, pair_max, win_max;
  logic signed [BITWIDTH-1:0] out_data_q;
  logic                       out_valid_q, out_last_q;

  logic in_ready, accept, last_beat, out_hs;

  assign in_px     = $signed(bus.in_data);
  assign lb_idx    = LW'(col >> 1);
  assign lb_rd     = linebuf[lb_idx];
  assign in_ready  = (state == RUN) && (!out_valid_q || bus.out_ready);
  assign accept    = bus.in_valid && in_ready;
  assign out_hs    = out_valid_q && bus.out_ready;
  assign last_beat = (ch == CH_MAX) && (row == DIM_MAX) && (col == DIM_MAX);

  max2_signed #(.WIDTH(BITWIDTH)) u_pair_max (.a(pair),  .b(in_px),    .y(pair_max));
  max2_signed #(.WIDTH(BITWIDTH)) u_win_max  (.a(lb_rd), .b(pair_max), .y(win_max));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (accept && last_beat) state_next = DRAIN;
      DRAIN:   if (out_hs) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Raster counters: col wraps into row, row wraps into channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
      ch  <= '0;
    end else if (state == IDLE && bus.start) begin
      col <= '0;
      row <= '0;
      ch  <= '0;
    end else if (accept) begin
      if (col == DIM_MAX) begin
        col <= '0;
        if (row == DIM_MAX) begin
          row <= '0;
          ch  <= (ch == CH_MAX) ? '0 : ch + 1'b1;
        end else begin
          row <= row + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Pair register on even columns; top-row pair maxima into the line buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      pair <= '0;
      for (int i = 0; i < OUT_DIM; i++) linebuf[i] <= '0;
    end else if (accept) begin
      if (!col[0])      pair            <= in_px;
      else if (!row[0]) linebuf[lb_idx] <= pair_max;
    end
  end

  // Output register: load on a completed window, hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (accept && col[0] && row[0]) begin
      out_data_q  <= win_max;
      out_valid_q <= 1'b1;
      out_last_q  <= last_beat;
    end else if (out_hs) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_maxpool_stream_ctrl.sv
// Self-checking bench for maxpool_stream_ctrl: random/directed frames against
// a plain-arithmetic pooling model, checked every cycle by one monitor.
module tb_maxpool_stream_ctrl;
  localparam int BW    = 16;
  localparam int CH    = 2;
  localparam int D     = 10;
  localparam int OD    = D / 2;
  localparam int TOTAL = CH * D * D;
  localparam int NOUT  = CH * OD * OD;

  logic clk, rst;
  maxpool_stream_ctrl_if #(.BITWIDTH(BW)) bus ();

  maxpool_stream_ctrl #(.BITWIDTH(BW), .CHANNELS(CH), .IN_DIM(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame stimulus and expected pooled map.
  int pix  [TOTAL];
  int expv [NOUT];
  int got  [NOUT];

  // Model state, owned by the monitor.
  int acc_cnt = 0, wins = 0, outs = 0, frames_done = 0;
  bit in_frame = 0, fin_pend = 0, prev_stall = 0;
  int prev_data = 0;

  // Driver knobs.
  int vld_pct = 100, rdy_pct = 100;
  bit drain_hold = 0;

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected map: plain 2x2 maximum over the stored frame.
  task automatic build_model();
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < OD; i++)
        for (int j = 0; j < OD; j++) begin
          int m;
          m = pix[(c*D + 2*i)*D + 2*j];
          for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++)
              if (pix[(c*D + 2*i + a)*D + 2*j + b] > m) m = pix[(c*D + 2*i + a)*D + 2*j + b];
          expv[(c*OD + i)*OD + j] = m;
        end
  endtask

  task automatic fill_ramp();
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < D; r++)
        for (int k = 0; k < D; k++) pix[(c*D + r)*D + k] = c*100 + r*10 + k;
  endtask

  task automatic fill_negative();
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < D; r++)
        for (int k = 0; k < D; k++) pix[(c*D + r)*D + k] = -(r*10 + k) - 1 - c*100;
  endtask

  task automatic fill_random();
    logic [BW-1:0] t;
    for (int n = 0; n < TOTAL; n++) begin
      t = BW'($urandom);
      pix[n] = int'($signed(t));
    end
  endtask

  // Input/ready driver: changes inputs 1 time unit after each rising edge.
  initial begin
    int v;
    logic [BW-1:0] d;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.in_valid = in_frame && (acc_cnt < TOTAL) && ($urandom_range(0, 99) < vld_pct);
      v = (acc_cnt < TOTAL) ? pix[acc_cnt] : 0;
      d = v[BW-1:0];
      bus.in_data = d;
      if (drain_hold && acc_cnt == TOTAL) bus.out_ready = 1'b0;
      else                                bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  // Monitor: compares every cycle on the falling edge, then advances the model
  // by the handshakes that the coming rising edge will complete.
  always @(negedge clk) begin
    bit exp_valid, exp_ir;
    int od;
    if (rst) begin
      in_frame = 0; fin_pend = 0; prev_stall = 0;
      acc_cnt = 0; wins = 0; outs = 0;
    end else begin
      exp_valid = (wins > outs);
      exp_ir = in_frame && !fin_pend && (acc_cnt < TOTAL) && (!exp_valid || bus.out_ready);
      od = int'($signed(bus.out_data));
      chk("out_valid", int'(bus.out_valid), int'(exp_valid));
      chk("in_ready",  int'(bus.in_ready),  int'(exp_ir));
      chk("busy",      int'(bus.busy),      int'(in_frame));
      chk("done",      int'(bus.done),      int'(fin_pend));
      if (exp_valid) begin
        chk("out_data", od, expv[outs]);
        chk("out_last", int'(bus.out_last), int'(outs == NOUT - 1));
      end else begin
        chk("out_last_idle", int'(bus.out_last), 0);
      end
      if (prev_stall) chk("stall_stable", od, prev_data);
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = od;

      if (fin_pend) begin
        in_frame = 0;
        fin_pend = 0;
        frames_done++;
      end else if (!in_frame && bus.start) begin
        in_frame = 1;
        acc_cnt = 0; wins = 0; outs = 0;
      end
      if (in_frame && exp_valid && bus.out_valid && bus.out_ready) begin
        got[outs] = od;
        outs++;
        if (outs == NOUT) fin_pend = 1;
      end
      if (in_frame && bus.in_valid && bus.in_ready && acc_cnt < TOTAL) begin
        if ((acc_cnt % 2 == 1) && ((acc_cnt / D) % 2 == 1)) wins++;
        acc_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start_now();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int f0, n;
    f0 = frames_done;
    n = 0;
    while (frames_done == f0 && n < 5000) begin
      tick();
      n++;
    end
    if (frames_done == f0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: no done within %0d cycles, expected one done pulse", name, n);
    end
  endtask

  task automatic wait_acc(input int target);
    int n;
    n = 0;
    while (acc_cnt < target && n < 5000) begin
      tick();
      n++;
    end
    if (acc_cnt < target) begin
      n_checks++; n_fail++;
      $display("FAIL wait_acc: accepted %0d beats, expected %0d", acc_cnt, target);
    end
  endtask

  task automatic run_frame(input string name);
    build_model();
    tick();
    pulse_start_now();
    wait_done(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd;
    rst = 1'b1;
    bus.start = 1'b0;
    fill_ramp();
    build_model();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    tick();
    chk("rst_busy",      int'(bus.busy),      0);
    chk("rst_done",      int'(bus.done),      0);
    chk("rst_in_ready",  int'(bus.in_ready),  0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_last",  int'(bus.out_last),  0);
    chk("rst_out_data",  int'(bus.out_data),  0);

    // Ramp frame, free-flowing output.
    vld_pct = 100; rdy_pct = 100;
    fill_ramp();
    build_model();
    chk("model_ramp_first", expv[0], 11);
    chk("model_ramp_last",  expv[NOUT-1], 199);
    run_frame("ramp");
    chk("ramp_first", got[0], 11);
    chk("ramp_mid",   got[OD*OD-1], 99);
    chk("ramp_last",  got[NOUT-1], 199);

    // All-negative frame: signed compare picks the smallest magnitude.
    fill_negative();
    run_frame("negative");
    chk("neg_first", got[0], -1);
    chk("neg_ch0_last", got[OD*OD-1], -89);

    // Tie window and mixed-sign window in channel 0.
    fill_random();
    pix[0] = 32767; pix[1] = 32767; pix[D] = 32767; pix[D+1] = 32767;
    pix[2] = -32768; pix[3] = 5; pix[D+2] = 5; pix[D+3] = -1;
    run_frame("tie_mixed");
    chk("tie_window",   got[0], 32767);
    chk("mixed_window", got[1], 5);

    // Continuous input, 30% output ready.
    vld_pct = 100; rdy_pct = 30;
    fill_random();
    run_frame("stall30");

    // Abort by reset after 37 accepted beats, then a clean ramp frame.
    vld_pct = 100; rdy_pct = 100;
    fill_ramp();
    build_model();
    tick();
    pulse_start_now();
    wait_acc(37);
    fd = frames_done;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("abort_no_done", frames_done, fd);
    chk("abort_busy", int'(bus.busy), 0);
    run_frame("after_abort");
    chk("after_abort_first", got[0], 11);
    chk("after_abort_last",  got[NOUT-1], 199);

    // start pulsed during RUN and during DRAIN is ignored.
    vld_pct = 80; rdy_pct = 50; drain_hold = 1;
    fill_random();
    build_model();
    tick();
    pulse_start_now();
    wait_acc(60);
    pulse_start_now();
    wait_acc(TOTAL);
    chk("drain_busy", int'(bus.busy), 1);
    pulse_start_now();
    repeat (4) tick();
    drain_hold = 0;
    wait_done("start_ignored");

    // Back-to-back frames: second start in the IDLE cycle after done.
    vld_pct = 100; rdy_pct = 100;
    fill_random();
    run_frame("b2b_first");
    chk("b2b_idle_busy", int'(bus.busy), 0);
    fill_random();
    build_model();
    pulse_start_now();
    wait_done("b2b_second");
    vld_pct = 70; rdy_pct = 60;
    fill_random();
    build_model();
    pulse_start_now();
    wait_done("b2b_third");

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
